// File: rtl/pciecfg_pkg.sv
// Shared types and constants for the PCIe configuration-access channel.
// The request entry carries the raw L2-L4 header so the core can build the reply.
package pciecfg_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPPROTO_UDP    = 8'd17;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [7:0]  PCIECFG_OPC_RD = 8'h01;
    localparam logic [7:0]  PCIECFG_OPC_WR = 8'h02;

    // hdr holds frame byte n at hdr[8n+7:8n]
    typedef struct packed {
        logic [319:0] hdr;
        logic [15:0]  udp_check;
        logic [7:0]   opcode;
        logic [3:0]   byte_mask;
        logic [9:0]   dwaddr;
        logic [31:0]  data;
    } pciecfg_pkt_t;

    typedef struct packed {
        logic         data_valid;
        pciecfg_pkt_t pkt;
    } FIFO_PCIECFG_T;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DRAIN} rx_state_t;

endpackage

// File: rtl/pciecfg_rx.sv
// Ingress parser: filters IPv4/UDP config frames off the MAC stream and
// writes one request entry per accepted frame into the core's FIFO.
module pciecfg_rx
    import pciecfg_pkg::*;
#(
    parameter logic [15:0] UDP_PORT = 16'h3000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [63:0]   s_axis_tdata,
    input  logic [7:0]    s_axis_tkeep,
    input  logic          s_axis_tvalid,
    input  logic          s_axis_tlast,
    output logic          s_axis_tready,
    output logic          fifo_pciecfg_i_wr_en,
    input  logic          fifo_pciecfg_i_full,
    output FIFO_PCIECFG_T fifo_pciecfg_i_din,
    output logic [31:0]   stat_rx_ok,
    output logic [31:0]   stat_rx_drop
);

    rx_state_t     state;
    logic [2:0]    cnt;
    logic          bad;
    logic [319:0]  hdr;
    logic [15:0]   udp_check;
    logic [7:0]    opcode;
    logic [3:0]    byte_mask;
    logic [9:0]    dwaddr;
    logic [31:0]   data;
    logic          hit;
    logic          bad_now;
    FIFO_PCIECFG_T entry;
    logic [63:0]   d;
    logic          unused;

    assign s_axis_tready = 1'b1;
    assign d             = s_axis_tdata;
    assign unused        = ^s_axis_tkeep[7:2];

    // Filter checks for the beat currently on the bus
    always_comb begin
        hit = 1'b0;
        case (state)
            S_HDR: begin
                case (cnt)
                    3'd1: hit = ({d[39:32], d[47:40]} != ETHERTYPE_IPV4) || (d[55:48] != IP_VER_IHL);
                    3'd2: hit = (d[63:56] != IPPROTO_UDP);
                    3'd4: hit = ({d[39:32], d[47:40]} != UDP_PORT);
                    default: hit = 1'b0;
                endcase
            end
            S_PAYLOAD: hit = (s_axis_tkeep[1:0] != 2'b11) ||
                             ((opcode != PCIECFG_OPC_RD) && (opcode != PCIECFG_OPC_WR));
            default: hit = 1'b0;
        endcase
    end

    assign bad_now = bad | hit;

    // The low data half is still on the bus when the frame ends on beat 6
    always_comb begin
        entry                = '0;
        entry.data_valid     = 1'b1;
        entry.pkt.hdr        = hdr;
        entry.pkt.udp_check  = udp_check;
        entry.pkt.opcode     = opcode;
        entry.pkt.byte_mask  = byte_mask;
        entry.pkt.dwaddr     = dwaddr;
        entry.pkt.data       = (state == S_PAYLOAD) ? {data[31:16], d[7:0], d[15:8]} : data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= S_IDLE;
            cnt                  <= 3'd0;
            bad                  <= 1'b0;
            hdr                  <= '0;
            udp_check            <= '0;
            opcode               <= '0;
            byte_mask            <= '0;
            dwaddr               <= '0;
            data                 <= '0;
            fifo_pciecfg_i_wr_en <= 1'b0;
            fifo_pciecfg_i_din   <= '0;
            stat_rx_ok           <= '0;
            stat_rx_drop         <= '0;
        end else begin
            fifo_pciecfg_i_wr_en <= 1'b0;
            if (s_axis_tvalid) begin
                if (cnt != 3'd7) cnt <= cnt + 3'd1;
                bad <= bad_now;
                case (state)
                    S_IDLE: begin
                        hdr[63:0] <= d;
                        bad       <= 1'b0;
                        if (s_axis_tlast) begin
                            stat_rx_drop <= stat_rx_drop + 32'd1;
                            cnt          <= 3'd0;
                        end else begin
                            state <= S_HDR;
                        end
                    end
                    S_HDR: begin
                        case (cnt)
                            3'd1: hdr[127:64]  <= d;
                            3'd2: hdr[191:128] <= d;
                            3'd3: hdr[255:192] <= d;
                            3'd4: hdr[319:256] <= d;
                            default: begin
                                udp_check    <= {d[7:0], d[15:8]};
                                opcode       <= d[23:16];
                                byte_mask    <= d[27:24];
                                dwaddr       <= {d[33:32], d[47:40]};
                                data[31:16]  <= {d[55:48], d[63:56]};
                            end
                        endcase
                        if (s_axis_tlast) begin
                            stat_rx_drop <= stat_rx_drop + 32'd1;
                            state        <= S_IDLE;
                            cnt          <= 3'd0;
                        end else if (cnt == 3'd5) begin
                            state <= S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD, S_DRAIN: begin
                        if (state == S_PAYLOAD) data[15:0] <= {d[7:0], d[15:8]};
                        if (s_axis_tlast) begin
                            state <= S_IDLE;
                            cnt   <= 3'd0;
                            if (!bad_now && !fifo_pciecfg_i_full) begin
                                fifo_pciecfg_i_wr_en <= 1'b1;
                                fifo_pciecfg_i_din   <= entry;
                                stat_rx_ok           <= stat_rx_ok + 32'd1;
                            end else begin
                                stat_rx_drop <= stat_rx_drop + 32'd1;
                            end
                        end else begin
                            state <= S_DRAIN;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pciecfg_rx.sv
// Bench for pciecfg_rx: frames are byte arrays, expectations come from the
// frame-format rules applied to those bytes, checked every cycle.
module tb_pciecfg_rx;
    import pciecfg_pkg::*;

    localparam logic [15:0] PORT = 16'h3000;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   tdata;
    logic [7:0]    tkeep;
    logic          tvalid;
    logic          tlast;
    logic          tready;
    logic          wr_en;
    logic          full;
    FIFO_PCIECFG_T din;
    logic [31:0]   ok_cnt;
    logic [31:0]   drop_cnt;

    pciecfg_rx #(.UDP_PORT(PORT)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid),
        .s_axis_tlast(tlast), .s_axis_tready(tready),
        .fifo_pciecfg_i_wr_en(wr_en), .fifo_pciecfg_i_full(full),
        .fifo_pciecfg_i_din(din), .stat_rx_ok(ok_cnt), .stat_rx_drop(drop_cnt)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    bit            chk_en = 1'b0;
    logic [7:0]    frm[$];
    bit            exp_wr;
    FIFO_PCIECFG_T exp_din;
    logic [31:0]   exp_ok;
    logic [31:0]   exp_drop;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic model_reset();
        exp_wr = 1'b0; exp_din = '0; exp_ok = '0; exp_drop = '0;
    endtask

    // Frame outcome from its bytes alone
    task automatic evaluate();
        int L;
        bit good;
        FIFO_PCIECFG_T e;
        L = frm.size();
        good = (L >= 50) && frm[12] == 8'h08 && frm[13] == 8'h00 && frm[14] == 8'h45 &&
               frm[23] == 8'd17 && {frm[36], frm[37]} == PORT &&
               (frm[42] == PCIECFG_OPC_RD || frm[42] == PCIECFG_OPC_WR);
        if (good && !full) begin
            e = '0;
            e.data_valid = 1'b1;
            for (int i = 0; i < 40; i++) e.pkt.hdr[8*i +: 8] = frm[i];
            e.pkt.udp_check = {frm[40], frm[41]};
            e.pkt.opcode    = frm[42];
            e.pkt.byte_mask = frm[43][3:0];
            e.pkt.dwaddr    = {frm[44][1:0], frm[45]};
            e.pkt.data      = {frm[46], frm[47], frm[48], frm[49]};
            exp_din = e;
            exp_wr  = 1'b1;
            exp_ok  = exp_ok + 1;
        end else begin
            exp_drop = exp_drop + 1;
        end
    endtask

    task automatic tick(input bit last);
        @(posedge clk);
        if (rst) model_reset();
        else begin
            exp_wr = 1'b0;
            if (last && tvalid) evaluate();
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tready", {63'd0, tready}, 64'd1);
            chk("wr_en", {63'd0, wr_en}, {63'd0, exp_wr});
            chk("stat_rx_ok", {32'd0, ok_cnt}, {32'd0, exp_ok});
            chk("stat_rx_drop", {32'd0, drop_cnt}, {32'd0, exp_drop});
            n_vec++;
            if (din !== exp_din) begin
                n_err++;
                $display("FAIL din: got %h expected %h", din, exp_din);
            end
        end
    end

    task automatic mk_valid(input int L, input logic [7:0] opc, input logic [9:0] dw,
                            input logic [31:0] dat, input logic [3:0] bm);
        int sz;
        sz = (L < 50) ? 50 : L;
        frm.delete();
        for (int i = 0; i < sz; i++) frm.push_back(8'($urandom));
        frm[12] = 8'h08; frm[13] = 8'h00; frm[14] = 8'h45; frm[23] = 8'd17;
        frm[36] = PORT[15:8]; frm[37] = PORT[7:0];
        frm[42] = opc;
        frm[43] = {frm[43][7:4], bm};
        frm[44] = {frm[44][7:2], dw[9:8]};
        frm[45] = dw[7:0];
        frm[46] = dat[31:24]; frm[47] = dat[23:16]; frm[48] = dat[15:8]; frm[49] = dat[7:0];
        while (frm.size() > L) void'(frm.pop_back());
    endtask

    // fmode: 0/1 = full value on the tlast beat, 2 = random
    task automatic send(input int max_beats, input int gap_pct, input int fmode);
        int L, n, lim, idx;
        L = frm.size();
        n = (L + 7) / 8;
        lim = (max_beats > 0 && max_beats < n) ? max_beats : n;
        for (int b = 0; b < lim; b++) begin
            while (b > 0 && $urandom_range(99) < gap_pct) begin
                tvalid = 1'b0; tlast = 1'b0; full = 1'($urandom_range(1));
                tick(1'b0);
            end
            tvalid = 1'b1;
            tlast  = (b == n - 1);
            for (int j = 0; j < 8; j++) begin
                idx = 8*b + j;
                tdata[8*j +: 8] = (idx < L) ? frm[idx] : 8'h00;
                tkeep[j]        = (idx < L);
            end
            if (tlast && fmode != 2) full = 1'(fmode);
            else full = ($urandom_range(3) == 0);
            tick(tlast);
        end
        tvalid = 1'b0; tlast = 1'b0; full = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1; tvalid = 1'b0; tlast = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    initial begin
        int L, sel;
        rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tkeep = '0; tdata = '0; full = 1'b0;
        model_reset();
        tick(1'b0);
        chk_en = 1'b1;
        do_reset();

        // Valid read
        mk_valid(56, PCIECFG_OPC_RD, 10'h004, 32'h12345678, 4'h3);
        send(0, 0, 0);
        chk("rd_wr_en", {63'd0, wr_en}, 64'd1);
        chk("rd_dwaddr", {54'd0, din.pkt.dwaddr}, 64'h004);
        chk("rd_data", {32'd0, din.pkt.data}, 64'h12345678);
        chk("rd_valid", {63'd0, din.data_valid}, 64'd1);
        chk("rd_ok", {32'd0, ok_cnt}, 64'd1);
        idle(3);

        // Filter misses: ARP, wrong port, runt
        do_reset();
        mk_valid(60, PCIECFG_OPC_RD, 10'h010, 32'hA5A5A5A5, 4'h1);
        frm[13] = 8'h06;
        send(0, 0, 0);
        mk_valid(60, PCIECFG_OPC_RD, 10'h010, 32'hA5A5A5A5, 4'h1);
        frm[37] = 8'h01;
        send(0, 0, 0);
        mk_valid(40, PCIECFG_OPC_RD, 10'h010, 32'hA5A5A5A5, 4'h1);
        send(0, 0, 0);
        idle(2);
        chk("miss_drop", {32'd0, drop_cnt}, 64'd3);
        chk("miss_ok", {32'd0, ok_cnt}, 64'd0);

        // FIFO full on tlast, then retry with room
        do_reset();
        mk_valid(56, PCIECFG_OPC_WR, 10'h3FF, 32'hDEADBEEF, 4'hF);
        send(0, 0, 1);
        idle(2);
        chk("full_drop", {32'd0, drop_cnt}, 64'd1);
        send(0, 0, 0);
        chk("full_mask", {60'd0, din.pkt.byte_mask}, 64'hF);
        chk("full_wr", {63'd0, wr_en}, 64'd1);
        idle(2);

        // Back-to-back with internal gaps
        mk_valid(56, PCIECFG_OPC_RD, 10'h021, 32'h01020304, 4'h5);
        send(0, 40, 0);
        mk_valid(56, PCIECFG_OPC_WR, 10'h042, 32'h05060708, 4'hA);
        send(0, 40, 0);
        chk("b2b_data", {32'd0, din.pkt.data}, 64'h05060708);
        idle(2);

        // Padded 64-byte frame
        mk_valid(64, PCIECFG_OPC_RD, 10'h155, 32'hCAFEF00D, 4'h7);
        send(0, 0, 0);
        chk("pad_data", {32'd0, din.pkt.data}, 64'hCAFEF00D);
        idle(2);

        // Reset mid-frame
        mk_valid(56, PCIECFG_OPC_RD, 10'h004, 32'h11112222, 4'h1);
        send(3, 0, 0);
        rst = 1'b1; tvalid = 1'b1;
        tick(1'b0);
        rst = 1'b0; tvalid = 1'b0;
        idle(2);
        chk("rstmid_ok", {32'd0, ok_cnt}, 64'd0);
        chk("rstmid_drop", {32'd0, drop_cnt}, 64'd0);
        mk_valid(56, PCIECFG_OPC_WR, 10'h008, 32'h33334444, 4'h2);
        send(0, 0, 0);
        idle(1);
        chk("rstmid_after", {32'd0, ok_cnt}, 64'd1);

        // Randomized traffic
        for (int f = 0; f < 150; f++) begin
            sel = $urandom_range(99);
            if (sel < 70) L = $urandom_range(50, 100);
            else if (sel < 85) L = 49;
            else L = $urandom_range(1, 48);
            mk_valid(L, ($urandom_range(1) != 0) ? PCIECFG_OPC_WR : PCIECFG_OPC_RD,
                     10'($urandom), $urandom, 4'($urandom));
            if (L >= 50 && $urandom_range(99) < 30) begin
                case ($urandom_range(5))
                    0: frm[12] = frm[12] ^ (8'h01 << $urandom_range(7));
                    1: frm[14] = frm[14] ^ (8'h01 << $urandom_range(7));
                    2: frm[23] = frm[23] ^ (8'h01 << $urandom_range(7));
                    3: frm[36] = frm[36] ^ (8'h01 << $urandom_range(7));
                    4: frm[37] = frm[37] ^ (8'h01 << $urandom_range(7));
                    default: frm[42] = 8'($urandom_range(3, 255));
                endcase
            end
            send(0, 20, 2);
            if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
